// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring_monitor block: FSM state enum,
// width-generic rotate-left and index-width helper.
package ring_pkg;

   typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

   localparam int unsigned MAX_N = 64;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Rotates the low w bits of x left by one; bits above w return 0.
   function automatic logic [MAX_N-1:0] rotl(input logic [MAX_N-1:0] x, input int unsigned w);
      logic [MAX_N-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < w; i++) begin
         r[(i + 1) % w] = x[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/ring_monitor_if.sv
// Sample/status bundle between a ring source and ring_monitor.
interface ring_monitor_if
   import ring_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned ERR_W = 8
);
   localparam int unsigned IW = idx_w(N);

   logic          in_en;
   logic [N-1:0]  ring_in;
   logic [IW-1:0] index;
   logic          index_valid;
   logic          wrap;
   logic          locked;
   logic          err_pulse;
   logic [ERR_W-1:0] err_count;

   modport master (
      output in_en, ring_in,
      input  index, index_valid, wrap, locked, err_pulse, err_count
   );

   modport slave (
      input  in_en, ring_in,
      output index, index_valid, wrap, locked, err_pulse, err_count
   );
endinterface

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot check and binary encoder for an N-bit ring word.
module ring_onehot_enc
   import ring_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         i_ring,
   output logic                 o_onehot,
   output logic [idx_w(N)-1:0]  o_index
);
   localparam int unsigned IW = idx_w(N);

   logic [N-1:0]  w_minus1;
   logic [IW-1:0] w_index;

   assign w_minus1 = i_ring - N'(1);
   assign o_onehot = (i_ring != '0) && ((i_ring & w_minus1) == '0);

   always_comb begin
      w_index = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (i_ring[i]) w_index = w_index | IW'(i);
      end
   end

   assign o_index = w_index;
endmodule

// File: rtl/ring_monitor.sv
// One-hot rotating ring checker: lock FSM, sequence errors and wrap detect.
// Define RING_MONITOR_ERRCNT_EN to implement the saturating err_count register.
module ring_monitor
   import ring_pkg::*;
#(
   parameter int unsigned N        = 4,
   parameter int unsigned LOCK_CNT = 3,
   parameter int unsigned ERR_W    = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   ring_monitor_if.slave mon
);
   localparam int unsigned IW = idx_w(N);
   localparam int unsigned RW = idx_w(LOCK_CNT + 1);

   state_t        r_state;
   logic [RW-1:0] r_run;
   logic [N-1:0]  r_prev;
   logic [IW-1:0] r_index;
   logic          r_index_valid;
   logic          r_wrap;
   logic          r_locked;
   logic          r_err_pulse;

   logic             w_onehot;
   logic [IW-1:0]    w_idx;
   logic [MAX_N-1:0] w_rot;
   logic [N-1:0]     w_exp;
   logic             w_correct;
   logic             w_err;

   ring_onehot_enc #(.N(N)) u_enc (
      .i_ring   (mon.ring_in),
      .o_onehot (w_onehot),
      .o_index  (w_idx)
   );

   assign w_rot     = rotl(MAX_N'(r_prev), N);
   assign w_exp     = w_rot[N-1:0];
   assign w_correct = w_onehot && (mon.ring_in == w_exp);
   assign w_err     = mon.in_en && (r_state == LOCKED) && !w_correct;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= HUNT;
         r_run         <= '0;
         r_prev        <= '0;
         r_index       <= '0;
         r_index_valid <= 1'b0;
         r_wrap        <= 1'b0;
         r_locked      <= 1'b0;
         r_err_pulse   <= 1'b0;
      end else begin
         r_index_valid <= 1'b0;
         r_wrap        <= 1'b0;
         r_err_pulse   <= 1'b0;
         if (mon.in_en) begin
            r_index_valid <= w_onehot;
            r_wrap        <= w_correct && r_prev[N-1];
            if (w_onehot) begin
               r_prev  <= mon.ring_in;
               r_index <= w_idx;
            end
            case (r_state)
               HUNT: begin
                  if (w_onehot) begin
                     if (LOCK_CNT == 1) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                     end else begin
                        r_state <= ACQ;
                        r_run   <= RW'(1);
                     end
                  end
               end
               ACQ: begin
                  if (w_correct) begin
                     if (int'(r_run) + 1 >= int'(LOCK_CNT)) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                     end else begin
                        r_run <= r_run + 1'b1;
                     end
                  end else if (w_onehot) begin
                     r_run <= RW'(1);
                  end else begin
                     r_state <= HUNT;
                  end
               end
               LOCKED: begin
                  if (w_err) begin
                     r_err_pulse <= 1'b1;
                     r_locked    <= 1'b0;
                     r_run       <= RW'(1);
                     r_state     <= w_onehot ? ACQ : HUNT;
                  end
               end
               default: begin
                  r_state  <= HUNT;
                  r_locked <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef RING_MONITOR_ERRCNT_EN
   logic [ERR_W-1:0] r_err_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err_count <= '0;
      end else if (w_err && (r_err_count != '1)) begin
         r_err_count <= r_err_count + 1'b1;
      end
   end

   assign mon.err_count = r_err_count;
`else
   assign mon.err_count = '0;
`endif

   assign mon.index       = r_index;
   assign mon.index_valid = r_index_valid;
   assign mon.wrap        = r_wrap;
   assign mon.locked      = r_locked;
   assign mon.err_pulse   = r_err_pulse;
endmodule

// File: tb/tb_ring_monitor.sv
// Self-checking bench for ring_monitor: directed plan plus randomized stream
// against a run-length reference model; two DUTs differ only in ERR_W.
module tb_ring_monitor;
   localparam int LC = 3;

   logic clk;
   logic rst_n;

   ring_monitor_if #(.N(4), .ERR_W(8)) ifa ();
   ring_monitor_if #(.N(4), .ERR_W(2)) ifb ();

   ring_monitor #(.N(4), .LOCK_CNT(3), .ERR_W(8)) u_a (.clk(clk), .rst_n(rst_n), .mon(ifa));
   ring_monitor #(.N(4), .LOCK_CNT(3), .ERR_W(2)) u_b (.clk(clk), .rst_n(rst_n), .mon(ifb));

   logic       in_en;
   logic [3:0] ring_in;
   assign ifa.in_en   = in_en;
   assign ifa.ring_in = ring_in;
   assign ifb.in_en   = in_en;
   assign ifb.ring_in = ring_in;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // Reference model: lock is "run of consecutive correct samples >= LOCK_CNT".
   int       m_run;
   int       m_prev;
   int       e_index, e_iv, e_wrap, e_err, e_cnt8, e_cnt2;
   bit       errcnt_on;

   function automatic int rot4(input int p);
      return ((p * 2) % 16) + (p / 8);
   endfunction

   function automatic int pos_of(input int v);
      int r = 0;
      for (int i = 0; i < 4; i++) if (((v >> i) & 1) == 1) r = i;
      return r;
   endfunction

   initial begin
`ifdef RING_MONITOR_ERRCNT_EN
      errcnt_on = 1'b1;
`else
      errcnt_on = 1'b0;
`endif
   end

   always @(posedge clk) begin
      int  v;
      bit  oh, corr, err;
      v = int'(ring_in);
      if (!rst_n) begin
         m_run = 0; m_prev = 0; e_index = 0; e_iv = 0; e_wrap = 0;
         e_err = 0; e_cnt8 = 0; e_cnt2 = 0;
      end else begin
         e_iv = 0; e_wrap = 0; e_err = 0;
         if (in_en) begin
            oh   = ($countones(ring_in) == 1);
            corr = oh && (v == rot4(m_prev));
            err  = 1'b0;
            e_iv   = oh;
            e_wrap = corr && (m_prev >= 8);
            if (!oh) begin
               if (m_run >= LC) err = 1'b1;
               m_run = 0;
            end else if (corr && m_run > 0) begin
               m_run++;
            end else begin
               if (m_run >= LC) err = 1'b1;
               m_run = 1;
            end
            if (oh) begin
               m_prev  = v;
               e_index = pos_of(v);
            end
            e_err = err;
            if (err && errcnt_on) begin
               if (e_cnt8 < 255) e_cnt8++;
               if (e_cnt2 < 3)   e_cnt2++;
            end
         end
      end
      #1;
      chk("index_a",  int'(ifa.index),       e_index);
      chk("ivalid_a", int'(ifa.index_valid), e_iv);
      chk("wrap_a",   int'(ifa.wrap),        e_wrap);
      chk("locked_a", int'(ifa.locked),      int'(m_run >= LC));
      chk("err_a",    int'(ifa.err_pulse),   e_err);
      chk("cnt_a",    int'(ifa.err_count),   e_cnt8);
      chk("index_b",  int'(ifb.index),       e_index);
      chk("locked_b", int'(ifb.locked),      int'(m_run >= LC));
      chk("err_b",    int'(ifb.err_pulse),   e_err);
      chk("cnt_b",    int'(ifb.err_count),   e_cnt2);
   end

   task automatic samp(input logic en, input logic [3:0] v);
      @(negedge clk);
      in_en   = en;
      ring_in = v;
      @(posedge clk);
      #2;
   endtask

   initial begin
      int p;
      rst_n = 1'b0; in_en = 1'b0; ring_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (5) samp(1'b0, 4'b0000);
      chk("lit_idle_index",  int'(ifa.index), 0);
      chk("lit_idle_locked", int'(ifa.locked), 0);
      chk("lit_idle_err",    int'(ifa.err_pulse), 0);

      samp(1'b1, 4'b0001);
      samp(1'b1, 4'b0010);
      chk("lit_pre_lock", int'(ifa.locked), 0);
      samp(1'b1, 4'b0100);
      chk("lit_lock", int'(ifa.locked), 1);
      samp(1'b1, 4'b1000);
      chk("lit_index3", int'(ifa.index), 3);
      chk("lit_nowrap", int'(ifa.wrap), 0);
      samp(1'b1, 4'b0001);
      chk("lit_index0", int'(ifa.index), 0);
      chk("lit_wrap",   int'(ifa.wrap), 1);

      samp(1'b1, 4'b0100);
      chk("lit_skip_err",    int'(ifa.err_pulse), 1);
      chk("lit_skip_unlock", int'(ifa.locked), 0);
      chk("lit_skip_cnt",    int'(ifa.err_count), errcnt_on ? 1 : 0);
      samp(1'b1, 4'b1000);
      samp(1'b1, 4'b0001);
      samp(1'b1, 4'b0010);
      chk("lit_relock", int'(ifa.locked), 1);

      samp(1'b1, 4'b0110);
      chk("lit_noh_err",  int'(ifa.err_pulse), 1);
      chk("lit_noh_iv",   int'(ifa.index_valid), 0);
      chk("lit_noh_hold", int'(ifa.index), 1);
      samp(1'b1, 4'b0000);
      chk("lit_zero_noerr", int'(ifa.err_pulse), 0);

      samp(1'b1, 4'b0001); samp(1'b0, 4'b0000);
      samp(1'b1, 4'b0010); samp(1'b0, 4'b1111);
      chk("lit_gap_idle_iv", int'(ifa.index_valid), 0);
      samp(1'b1, 4'b0100);
      chk("lit_gap_lock", int'(ifa.locked), 1);

      for (int k = 0; k < 5; k++) begin
         samp(1'b1, 4'b0001);
         samp(1'b1, 4'b0010);
         samp(1'b1, 4'b0100);
      end
      chk("lit_sat_b", int'(ifb.err_count), errcnt_on ? 3 : 0);
      chk("lit_cnt_a", int'(ifa.err_count), errcnt_on ? 7 : 0);
      chk("lit_sat_locked", int'(ifb.locked), 1);

      @(negedge clk); rst_n = 1'b0; in_en = 1'b1; ring_in = 4'b1000;
      @(posedge clk); #2;
      chk("lit_rst_locked", int'(ifa.locked), 0);
      chk("lit_rst_cnt",    int'(ifb.err_count), 0);
      chk("lit_rst_iv",     int'(ifa.index_valid), 0);
      @(negedge clk); rst_n = 1'b1; in_en = 1'b0;

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 199) != 0);
         in_en = ($urandom_range(0, 3) != 0);
         p = $urandom_range(0, 99);
         if (p < 75)      ring_in = (m_prev == 0) ? 4'b0001 : 4'(rot4(m_prev));
         else if (p < 90) ring_in = 4'(1 << $urandom_range(0, 3));
         else             ring_in = 4'($urandom_range(0, 15));
      end
      @(negedge clk); rst_n = 1'b1; in_en = 1'b0;
      @(posedge clk); #2;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
